fb_rect_fill_ctrl: RTL
======================

Name: fb_rect_fill_ctrl

Overview:
Sequences rectangle-fill writes into the 800x480 1-bit framebuffer write port.
- Accepts one rectangle command at a time over a valid/ready handshake.
- Clips the rectangle to the active area and walks it in raster order, issuing one pixel write per accepted cycle.
- Sits between the host/command logic and the framebuffer write arbiter, replacing hard-coded per-pixel box generation.

Parameters:
H_ACTIVE, 800, active pixels per line; also the row pitch in framebuffer words
V_ACTIVE, 480, active lines
AW, 19, framebuffer address width; must satisfy 2^AW >= H_ACTIVE*V_ACTIVE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  rectangle command present
cmd_ready  out  1  controller can accept a command
cmd_x0  in  11  left column, inclusive
cmd_y0  in  11  top line, inclusive
cmd_x1  in  11  right column, inclusive
cmd_y1  in  11  bottom line, inclusive
cmd_color  in  1  pixel value to write
wr_en  out  1  write request to framebuffer
wr_addr  out  AW  write address = y*H_ACTIVE + x
wr_data  out  1  write data
wr_ready  in  1  framebuffer accepts the write this cycle
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes

Behaviour:
- One clock domain; rst is synchronous and active-high. All state is updated on posedge clk only.
- Reset values: state=IDLE, cmd_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- States and transitions:
  - IDLE: cmd_ready=1. When cmd_valid&&cmd_ready, latch the command fields and go to SETUP.
  - SETUP, one cycle: clip cx1=min(x1,H_ACTIVE-1) and cy1=min(y1,V_ACTIVE-1). Compute row_base=y0*H_ACTIVE, a registered constant multiply. If x0>cx1, y0>cy1, x0>=H_ACTIVE or y0>=V_ACTIVE, the command is empty: go to DONE without writing. Otherwise load x=x0, y=y0, addr=row_base+x0 and go to FILL.
  - FILL: wr_en=1, wr_addr=addr, wr_data=color.
    - Registered outputs hold stable while wr_ready=0.
    - On wr_en&&wr_ready with x<cx1: x+1, addr+1.
    - On wr_en&&wr_ready with x==cx1 and y<cy1: y+1, x=x0, row_base+=H_ACTIVE, addr=row_base+H_ACTIVE+x0.
    - On the accept of the last pixel (x==cx1, y==cy1): wr_en=0 next cycle and go to DONE.
  - DONE, one cycle: done=1, cmd_ready=0, then IDLE.
- busy=1 in SETUP, FILL and DONE; cmd_ready=0 in those states.
- Latency: command accepted in cycle T; first wr_en in T+2; done asserts in the cycle after the last write accept. An empty command gives done at T+2.
- Throughput: 1 pixel/cycle under continuous wr_ready. There is no idle gap at row wrap.
- Arithmetic: the x/y counters are 11 bits. addr is AW bits and never exceeds H_ACTIVE*V_ACTIVE-1, because of clipping.
- Command fields are sampled only at accept; later changes on cmd_* have no effect.
- rst mid-command: the next edge returns to the reset values. No done pulse is issued and the partial fill is abandoned.

Optional Feature:
FB_FILL_CHECKER_EN
- Defined: wr_data = cmd_color ^ x[0] ^ y[0], producing a 1-pixel checkerboard anchored to absolute coordinates.
- Undefined: wr_data = cmd_color for every pixel. No extra logic is present.

Test Plan:
- Rect (150,150)-(151,151), color 0, wr_ready=1 -> wr_addr sequence 120150,120151,120950,120951 with wr_data=0. First wr_en 2 cycles after accept; done 1 cycle after the 4th write.
- Same rect with wr_ready low for 3 cycles on the 2nd write -> wr_addr held at 120151 and wr_en held high for those 3 cycles. Still exactly 4 writes, same order.
- Rect (798,0)-(900,0) -> only addrs 798 and 799 are written, then done.
- Rect (10,5)-(9,5), x0>x1 -> no wr_en, done 2 cycles after accept, cmd_ready back high the cycle after done.
- Full screen (0,0)-(799,479) -> exactly 384000 writes, last wr_addr 383999, no gaps with wr_ready=1. With FB_FILL_CHECKER_EN and color 1, addr 0 gets data 1 and addr 1 gets data 0.
- Assert rst during FILL after 10 writes -> wr_en=0, busy=0, cmd_ready=1 on the next edge; no done pulse. A new command afterwards executes correctly.

Source files
------------

// File: rtl/fb_rect_fill_ctrl.sv
// fb_rect_fill_ctrl
//
// Purpose:
//   Takes one rectangle-fill command at a time and turns it into a raster-order
//   stream of single-pixel writes into the 800x480 1-bit framebuffer. The
//   rectangle is clipped to the active area. A command that is empty after
//   clipping completes without any write.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   cmd_valid  rectangle command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_x0     left column, inclusive (11 bits)
//   cmd_y0     top line, inclusive (11 bits)
//   cmd_x1     right column, inclusive (11 bits)
//   cmd_y1     bottom line, inclusive (11 bits)
//   cmd_color  pixel value to write
//   wr_en      write request to framebuffer
//   wr_addr    write address = y*H_ACTIVE + x
//   wr_data    write data
//   wr_ready   framebuffer accepts the write this cycle
//   busy       command in progress (SETUP, FILL, DONE)
//   done       one-cycle pulse when a command completes
//
// Optional feature macro: FB_FILL_CHECKER_EN
//   Defined   : wr_data = color ^ x[0] ^ y[0] (checkerboard on absolute coordinates)
//   Undefined : wr_data = color for every pixel

module fb_rect_fill_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [10:0]   cmd_x0,
  input  logic [10:0]   cmd_y0,
  input  logic [10:0]   cmd_x1,
  input  logic [10:0]   cmd_y1,
  input  logic          cmd_color,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_data,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } state_t;

  localparam logic [10:0]   X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   Y_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0]   X_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0]   Y_LIM  = 11'(V_ACTIVE);
  localparam logic [AW-1:0] PITCH  = AW'(H_ACTIVE);

  state_t state, state_next;

  logic [10:0]   x0_q, y0_q, x1_q, y1_q;
  logic          color_q;
  logic [10:0]   cx1, cy1;
  logic [10:0]   x, y;
  logic [AW-1:0] row_base;
  logic [AW-1:0] addr;

  logic [10:0]   cx1_clip, cy1_clip;
  logic          empty;
  logic          accept;
  logic          wr_fire;
  logic          last_col;
  logic          last_row;

  // Clipping of the latched corner against the active area, and the
  // empty-command test evaluated in SETUP. A start point outside the
  // active area is treated as empty even though the clipped end would
  // otherwise look valid.
  always_comb begin
    cx1_clip = (x1_q > X_LAST) ? X_LAST : x1_q;
    cy1_clip = (y1_q > Y_LAST) ? Y_LAST : y1_q;
    empty    = (x0_q > cx1_clip) || (y0_q > cy1_clip) ||
               (x0_q >= X_LIM)   || (y0_q >= Y_LIM);
    accept   = cmd_valid && cmd_ready;
    wr_fire  = wr_en && wr_ready;
    last_col = (x == cx1);
    last_row = (y == cy1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs. Every output is a pure function of the
  // state register, so nothing moves while the framebuffer stalls us.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = empty ? DONE : FILL;
      end
      FILL: begin
        wr_en = 1'b1;
        if (wr_ready && last_col && last_row) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch and raster walker. row_base is multiplied out at accept
  // time so SETUP only needs an add to form the first address. At a row
  // wrap the next address is built from the new row base directly, so the
  // wrap costs no extra cycle. For an empty command addr is left alone,
  // which keeps wr_addr inside the framebuffer at all times.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= 1'b0;
      cx1      <= '0;
      cy1      <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr     <= '0;
    end else begin
      if (accept) begin
        x0_q     <= cmd_x0;
        y0_q     <= cmd_y0;
        x1_q     <= cmd_x1;
        y1_q     <= cmd_y1;
        color_q  <= cmd_color;
        row_base <= AW'(cmd_y0) * PITCH;
      end
      if (state == SETUP) begin
        cx1 <= cx1_clip;
        cy1 <= cy1_clip;
        x   <= x0_q;
        y   <= y0_q;
        if (!empty) begin
          addr <= row_base + AW'(x0_q);
        end
      end
      if (wr_fire) begin
        if (!last_col) begin
          x    <= x + 11'd1;
          addr <= addr + AW'(1);
        end else if (!last_row) begin
          y        <= y + 11'd1;
          x        <= x0_q;
          row_base <= row_base + PITCH;
          addr     <= row_base + PITCH + AW'(x0_q);
        end
      end
    end
  end

  // Write port data path.
  always_comb begin
    wr_addr = addr;
`ifdef FB_FILL_CHECKER_EN
    wr_data = color_q ^ x[0] ^ y[0];
`else
    wr_data = color_q;
`endif
  end

endmodule
